// File: rtl/ram_burst_master.sv
// ram_burst_master: burst initiator for a single-port synchronous RAM.
// Takes one command at a time (start address, beat count, direction).
// Write bursts stream beats from a valid/ready channel straight to the RAM.
// Read bursts absorb the RAM's one-cycle read latency and return beats
// through a 2-entry FIFO with full backpressure.
module ram_burst_master #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  input  logic              rready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_wr,
  output logic              ram_rd,
  output logic              ram_cs,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   rem_q;
  logic                done_q;
  logic                inflight_q;
  logic [DATA_W-1:0]   fifo_mem [2];
  logic                rd_ptr, wr_ptr;
  logic [1:0]          fifo_count;

  logic                wr_hs;
  logic                issue;
  logic                pop;
  logic [2:0]          occ;

  // Read data lands in the FIFO the cycle after each issue.
  assign pop         = rvalid & rready;
  assign occ         = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
  assign rvalid      = (fifo_count != 2'd0);
  assign rdata       = fifo_mem[rd_ptr];
  assign done        = done_q;
  assign ram_address = addr_q;
  assign ram_data_in = wdata;

  // State register; an async reset drops every strobe the same instant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and strobe decode; the credit rule gates read issues.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d   = state_q;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    wready    = 1'b0;
    ram_cs    = 1'b0;
    ram_wr    = 1'b0;
    ram_rd    = 1'b0;
    wr_hs     = 1'b0;
    issue     = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_d = cmd_wr ? WRITE : READ;
      end
      WRITE: begin
        wready = 1'b1;
        wr_hs  = wvalid;
        ram_cs = wvalid;
        ram_wr = wvalid;
        if (wvalid && rem_q == '0) state_d = IDLE;
      end
      READ: begin
        issue  = (occ < 3'd2);
        ram_cs = issue;
        ram_rd = issue;
        if (issue && rem_q == '0) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_count == 2'd0 && !inflight_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst address/count, in-flight read flag and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      addr_q     <= '0;
      rem_q      <= '0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      done_q     <= (state_q == WRITE || state_q == DRAIN) && state_d == IDLE;
      if (state_q == IDLE && cmd_valid) begin
        addr_q <= cmd_addr;
        rem_q  <= cmd_len;
      end else if (wr_hs || issue) begin
        addr_q <= addr_q + ADDR_W'(1);
        rem_q  <= rem_q - ADDR_W'(1);
      end
    end
  end

  // Two-entry read FIFO; a push and pop in the same cycle keep the count.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the two storage words are reset too, so rdata reads zero out of reset instead of X.
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (inflight_q) begin
        fifo_mem[wr_ptr] <= ram_data_out;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({inflight_q, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: doc/ram_burst_master.md
# ram_burst_master

Burst-access initiator for the single-port 1024x8 synchronous RAM. Accepts one command at a time (start address, beat count, direction), then drives the RAM's address/data_in/wr/rd/cs pins. For writes it streams data from a valid/ready write channel. For reads it absorbs the RAM's one-cycle registered read latency and returns data on a valid/ready read channel with full backpressure. It sits between a host/DMA stream and the RAM instance.

## Interface
- ADDR_W, 10, RAM address width; burst addresses wrap modulo 2^ADDR_W
- DATA_W, 8, RAM data width
- clk  in  1  rising-edge clock, shared with the RAM
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high exactly when state==IDLE
- cmd_wr  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  start address
- cmd_len  in  ADDR_W  beats minus one (0 → 1 beat, 1023 → 1024 beats)
- wdata  in  DATA_W  write beat
- wvalid  in  1  write beat offered
- wready  out  1  write beat accepted when wvalid&wready
- rdata  out  DATA_W  read beat (FIFO head)
- rvalid  out  1  read beat offered
- rready  in  1  read beat consumed when rvalid&rready
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at burst completion
- ram_address  out  ADDR_W  to RAM address
- ram_data_in  out  DATA_W  to RAM data_in; equals wdata combinationally
- ram_wr, ram_rd, ram_cs  out  1  to RAM strobes; ram_wr and ram_rd are never both high
- ram_data_out  in  DATA_W  from RAM data_out

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_addr into addr_q and cmd_len into remaining count rem_q. Go to WRITE if cmd_wr, else READ.
- WRITE:
  - wready=1. ram_cs=ram_wr=wvalid. ram_address=addr_q.
  - Each handshake: addr_q ← addr_q+1 (wraps 1023→0), rem_q ← rem_q−1.
  - On the handshake with rem_q==0: go to IDLE and pulse done next cycle.
  - wvalid low inserts idle cycles with strobes low.
- READ:
  - Issue a read (ram_cs=ram_rd=1, ram_address=addr_q) when fifo_count + inflight − pop < 2. pop = rvalid&rready this cycle.
  - inflight is a 1-bit flag set in the cycle after an issue, i.e. the cycle ram_data_out is valid. In that cycle ram_data_out is pushed into a 2-entry FIFO.
  - Each issue: addr_q+1 (wrapping), rem_q−1. The issue at rem_q==0 moves to DRAIN.
- DRAIN: no issues. When the FIFO is empty, inflight=0, and the last beat has handshaken: go to IDLE and pulse done next cycle.
- FIFO: rvalid = fifo_count≠0; rdata = head entry. A simultaneous push and pop keeps the count. Overflow is impossible by the credit rule.
- Commands are ignored outside IDLE; cmd_ready stays 0.
- Reset mid-burst: immediate abort. All strobes go low asynchronously, so no partial RAM write occurs. FIFO and inflight clear, state goes to IDLE, no done pulse. RAM contents are untouched.

## Timing
- Reset values:
  - cmd_ready=1, busy=0, done=0
  - wready=0, rvalid=0, rdata=0
  - ram_cs=ram_wr=ram_rd=0, ram_address=0
  - ram_data_in follows wdata
- Command acceptance edge → first RAM strobe possible the following cycle.
- Write throughput: 1 beat/cycle. An N-beat burst with continuous wvalid: busy for N cycles, done the cycle after the last write edge.
- Read latency: issue cycle T. RAM registers data at the end of T; FIFO captures it at the end of T+1; rvalid is first high in T+2.
- Read throughput: 1 beat/cycle with rready held high. With rready low, at most 2 beats are buffered and issuing stalls. No beat is lost or duplicated.
- done: exactly one cycle per completed burst, coincident with busy falling.
- A new command may be accepted the same cycle done is high.

## Test plan
- Write then read, 4 beats at 0x010 (data A0,A1,A2,A3), rready=1 → rdata A0..A3 in order; first rvalid 2 cycles after the first ram_rd; one done per burst.
- Wrap burst: write cmd_addr=0x3FE, cmd_len=3 (data 11,22,33,44) → ram_address sequence 3FE,3FF,000,001. Read-back returns 11,22,33,44.
- Read backpressure: 8-beat read with rready toggling 1,0,0,1,… → all 8 beats delivered in order; fifo_count never exceeds 2; ram_rd stalls while full.
- Write stall: wvalid low for 3 cycles mid-burst → ram_wr low for those cycles; address does not advance; final contents correct.
- Reset during a 16-beat write after 5 beats → strobes drop the same cycle; cmd_ready=1, no done. Addresses 5..15 retain their prior values.
- Max burst cmd_len=1023 (full 1024-beat write/read) → every location checked; exactly one done per burst.
